// File: rtl/wshb_arb_pkg.sv
// Shared types for the two-requester Wishbone arbiter: FSM state encoding
// and the requester index used for ownership bookkeeping.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    typedef logic req_idx_t;

    function automatic arb_state_e grant_state(input req_idx_t idx);
        return idx ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone B4 bus bundle (no err/rty), shared by requesters and SDRAM port.
interface wshb_if #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_WIDTH = 32
);
    logic                      cyc;
    logic                      stb;
    logic                      we;
    logic                      ack;
    logic [ADDR_WIDTH-1:0]     adr;
    logic [8*DATA_BYTES-1:0]   dat_ms;
    logic [8*DATA_BYTES-1:0]   dat_sm;
    logic [DATA_BYTES-1:0]     sel;
    logic [2:0]                cti;
    logic [1:0]                bte;

    modport master (
        output cyc, stb, adr, dat_ms, we, sel, cti, bte,
        input  ack, dat_sm
    );

    modport slave (
        input  cyc, stb, adr, dat_ms, we, sel, cti, bte,
        output ack, dat_sm
    );
endinterface

// File: rtl/wshb_arbiter.sv
// Two-requester Wishbone arbiter sharing one SDRAM port between the video
// reader (requester 0) and the frame writer (requester 1).
//
// state  | meaning
// IDLE   | no owner; master cyc/stb held low, arbitration happens here
// GRANT0 | requester 0 owns the master port
// GRANT1 | requester 1 owns the master port
//
// Ownership only changes by passing through IDLE, so the shared port always
// sees at least one cycle with stb low between owners.
//
// Build option: define WSHB_ARB_BURST_LIMIT_EN to cap an owner at MAX_BURST
// acked transfers while the other requester waits. Without it the owner
// keeps the port until it stops requesting and MAX_BURST has no effect.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic   clk,
    input  logic   rst,
    wshb_if.slave  wshb_ifs0,
    wshb_if.slave  wshb_ifs1,
    wshb_if.master wshb_ifm
);

    arb_state_e state_q;
    req_idx_t   last_owner_q;

    logic       req0;
    logic       req1;
    logic       grant0;
    logic       grant1;
    req_idx_t   owner_idx;
    logic       owner_req;
    logic       other_req;
    req_idx_t   idle_pick;
    logic       burst_done;

    assign req0 = wshb_ifs0.cyc & wshb_ifs0.stb;
    assign req1 = wshb_ifs1.cyc & wshb_ifs1.stb;

    // rst gates the grants directly so nothing leaks out while reset is held
    assign grant0 = (state_q == GRANT0) & ~rst;
    assign grant1 = (state_q == GRANT1) & ~rst;

    assign owner_idx = (state_q == GRANT1);
    assign owner_req = owner_idx ? req1 : req0;
    assign other_req = owner_idx ? req0 : req1;

    // On a tie the requester that did not own the port last time wins
    assign idle_pick = req0 ? (req1 ? ~last_owner_q : 1'b0) : 1'b1;

    // MAX_BURST is only consumed by the burst limiter; a value below 1 is not
    // a meaningful limit in either build.
    if (MAX_BURST < 1) begin : g_max_burst_invalid
    end

`ifdef WSHB_ARB_BURST_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] burst_cnt_q;

    // Hand over on an ack boundary once the owner has had its share. Using >=
    // lets a saturated owner still yield when the other side shows up late.
    assign burst_done = wshb_ifm.ack & (burst_cnt_q >= CNT_LAST) & other_req;
`else
    assign burst_done = 1'b0;
`endif

    // Arbitration FSM, last-owner record and burst counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
`ifdef WSHB_ARB_BURST_LIMIT_EN
            burst_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 | req1) begin
                        state_q <= grant_state(idle_pick);
                    end
`ifdef WSHB_ARB_BURST_LIMIT_EN
                    burst_cnt_q <= '0;
`endif
                end
                GRANT0, GRANT1: begin
                    if (!owner_req || burst_done) begin
                        state_q      <= IDLE;
                        last_owner_q <= owner_idx;
                    end
`ifdef WSHB_ARB_BURST_LIMIT_EN
                    if (wshb_ifm.ack && (burst_cnt_q != CNT_MAX)) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Request-side mux: the owner's signals pass straight through to the master
    always_comb begin
        wshb_ifm.cyc    = 1'b0;
        wshb_ifm.stb    = 1'b0;
        wshb_ifm.we     = 1'b0;
        wshb_ifm.adr    = '0;
        wshb_ifm.dat_ms = '0;
        wshb_ifm.sel    = '0;
        wshb_ifm.cti    = '0;
        wshb_ifm.bte    = '0;
        if (grant0) begin
            wshb_ifm.cyc    = wshb_ifs0.cyc;
            wshb_ifm.stb    = wshb_ifs0.stb;
            wshb_ifm.we     = wshb_ifs0.we;
            wshb_ifm.adr    = wshb_ifs0.adr;
            wshb_ifm.dat_ms = wshb_ifs0.dat_ms;
            wshb_ifm.sel    = wshb_ifs0.sel;
            wshb_ifm.cti    = wshb_ifs0.cti;
            wshb_ifm.bte    = wshb_ifs0.bte;
        end else if (grant1) begin
            wshb_ifm.cyc    = wshb_ifs1.cyc;
            wshb_ifm.stb    = wshb_ifs1.stb;
            wshb_ifm.we     = wshb_ifs1.we;
            wshb_ifm.adr    = wshb_ifs1.adr;
            wshb_ifm.dat_ms = wshb_ifs1.dat_ms;
            wshb_ifm.sel    = wshb_ifs1.sel;
            wshb_ifm.cti    = wshb_ifs1.cti;
            wshb_ifm.bte    = wshb_ifs1.bte;
        end
    end

    // Acks go only to the owner; read data is broadcast and qualified by ack
    assign wshb_ifs0.ack    = grant0 & wshb_ifm.ack;
    assign wshb_ifs1.ack    = grant1 & wshb_ifm.ack;
    assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;

endmodule
